// File: rtl/hub_rd_arb_pkg.sv
// Shared constants and types for the hub read-port arbiter.
package hub_rd_arb_pkg;

    // Idle address: outside hub space, so the multNQ/offset translation is left alone.
    localparam logic [15:0] ADDR_HUB = 16'h0000;

    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_FW  = 2'd1,
        ST_GNT_ETH = 2'd2,
        ST_DRAIN   = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_FW  = 1'b0,
        SRC_ETH = 1'b1
    } src_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_FW   = 2'b01;
    localparam logic [1:0] OWN_ETH  = 2'b10;

    typedef struct packed {
        logic eth;
        logic fw;
    } rv_tag_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hub_rd_valid_pipe.sv
// Per-source read-valid tags delayed by the hub read latency.
module hub_rd_valid_pipe
    import hub_rd_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rv_tag_t tag_i,
    output rv_tag_t tag_o
);

    rv_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/hub_rd_arb.sv
// Burst-granular arbiter for the hub read port between FireWire and Ethernet.
// state      | meaning
// ST_IDLE    | no owner, reg_raddr parked at ADDR_HUB, arbitrate
// ST_GNT_FW  | FireWire owns the port
// ST_GNT_ETH | Ethernet owns the port
// ST_DRAIN   | RD_LAT-cycle gap so in-flight reads finish before a new owner
module hub_rd_arb
    import hub_rd_arb_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 11
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        fw_req,
    input  logic        fw_strobe,
    input  logic [15:0] fw_raddr,
    output logic        fw_gnt,
    output logic        fw_rvalid,
    input  logic        eth_req,
    input  logic        eth_strobe,
    input  logic [15:0] eth_raddr,
    output logic        eth_gnt,
    output logic        eth_rvalid,
    output logic [15:0] reg_raddr,
    input  logic [31:0] reg_rdata,
    output logic [31:0] hub_rdata,
    input  logic        bc_query,
    output logic        to_pulse,
    output logic [15:0] arb_status
);

    localparam int             DR_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_e      state_q, state_d;
    src_e            rr_q, rr_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [DR_W-1:0] drain_q, drain_d;
    logic [7:0]      burst_q, burst_d;
    logic [7:0]      last_q, last_d;
    logic            fw_to_q, fw_to_d, eth_to_q, eth_to_d;
    logic            fw_blk_q, fw_blk_d, eth_blk_q, eth_blk_d;
    logic            to_pulse_q;
    logic            fire_fw, fire_eth;
    logic            own_req, own_stb;
    logic            fw_ok, eth_ok;
    logic [1:0]      owner;
    logic [31:0]     data_q [RD_LAT];
    rv_tag_t         tag_in, tag_out;

    assign fw_ok  = fw_req  & ~fw_blk_q;
    assign eth_ok = eth_req & ~eth_blk_q;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        to_cnt_d = '0;
        drain_d  = drain_q;
        burst_d  = burst_q;
        last_d   = last_q;
        fire_fw  = 1'b0;
        fire_eth = 1'b0;
        own_req  = 1'b0;
        own_stb  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fw_ok && (!eth_ok || rr_q == SRC_ETH)) begin
                    state_d = ST_GNT_FW;
                    rr_d    = SRC_FW;
                end else if (eth_ok) begin
                    state_d = ST_GNT_ETH;
                    rr_d    = SRC_ETH;
                end
            end
            ST_GNT_FW, ST_GNT_ETH: begin
                own_req = (state_q == ST_GNT_FW) ? fw_req    : eth_req;
                own_stb = (state_q == ST_GNT_FW) ? fw_strobe : eth_strobe;
                if (own_stb) burst_d  = sat_inc8(burst_q);
                else         to_cnt_d = to_cnt_q + 1'b1;
                // Release wins over a coincident timeout; the strobe of the release cycle still counts.
                if (!own_req || (!own_stb && to_cnt_q == TO_LAST)) begin
                    state_d  = ST_DRAIN;
                    drain_d  = DR_W'(RD_LAT - 1);
                    to_cnt_d = '0;
                    last_d   = burst_d;
                    burst_d  = '0;
                    if (own_req) begin
                        fire_fw  = (state_q == ST_GNT_FW);
                        fire_eth = (state_q == ST_GNT_ETH);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_IDLE;
                else               drain_d = drain_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        fw_to_d   = fire_fw  ? 1'b1 : (bc_query ? 1'b0 : fw_to_q);
        eth_to_d  = fire_eth ? 1'b1 : (bc_query ? 1'b0 : eth_to_q);
        fw_blk_d  = fire_fw  ? 1'b1 : (!fw_req  ? 1'b0 : fw_blk_q);
        eth_blk_d = fire_eth ? 1'b1 : (!eth_req ? 1'b0 : eth_blk_q);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_q       <= SRC_ETH;
            to_cnt_q   <= '0;
            drain_q    <= '0;
            burst_q    <= '0;
            last_q     <= '0;
            fw_to_q    <= 1'b0;
            eth_to_q   <= 1'b0;
            fw_blk_q   <= 1'b0;
            eth_blk_q  <= 1'b0;
            to_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            to_cnt_q   <= to_cnt_d;
            drain_q    <= drain_d;
            burst_q    <= burst_d;
            last_q     <= last_d;
            fw_to_q    <= fw_to_d;
            eth_to_q   <= eth_to_d;
            fw_blk_q   <= fw_blk_d;
            eth_blk_q  <= eth_blk_d;
            to_pulse_q <= fire_fw | fire_eth;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            data_q[0] <= reg_rdata;
            for (int i = 1; i < RD_LAT; i++) data_q[i] <= data_q[i-1];
        end
    end

    assign tag_in.fw  = (state_q == ST_GNT_FW)  & fw_strobe;
    assign tag_in.eth = (state_q == ST_GNT_ETH) & eth_strobe;

    hub_rd_valid_pipe #(.DEPTH(RD_LAT)) u_valid_pipe (
        .clk   (sysclk),
        .rst_n (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        reg_raddr = ADDR_HUB;
        owner     = OWN_NONE;
        case (state_q)
            ST_GNT_FW: begin
                reg_raddr = fw_raddr;
                owner     = OWN_FW;
            end
            ST_GNT_ETH: begin
                reg_raddr = eth_raddr;
                owner     = OWN_ETH;
            end
            default: ;
        endcase
    end

    assign fw_gnt     = (state_q == ST_GNT_FW);
    assign eth_gnt    = (state_q == ST_GNT_ETH);
    assign fw_rvalid  = tag_out.fw;
    assign eth_rvalid = tag_out.eth;
    assign hub_rdata  = data_q[RD_LAT-1];
    assign to_pulse   = to_pulse_q;
    assign arb_status = {fw_to_q, eth_to_q, owner, 4'd0, last_q};

endmodule

// File: doc/hub_rd_arb.md
Name: hub_rd_arb

Overview:
- Arbitrates the single hub-memory read port (reg_raddr/reg_rdata into the hub register block) between the FireWire and Ethernet block-read engines.
- The hub read-address translation (multNQ/offset) is stateful and requires contiguous addresses from one master. This block therefore grants the port for a whole burst, never interleaves requesters, and inserts a drain gap between owners.
- It sits between the two bus engines and the hub register block. It also provides timeout recovery and a small status word.

Parameters:
- RD_LAT, 1, cycles from address presented to reg_rdata valid (hub BRAM registered read).
- TIMEOUT_CYC, 1024, idle cycles (granted, no strobe) before forced revoke (~21 us at 49.152 MHz).
- TO_W, 11, width of timeout counter; must hold TIMEOUT_CYC.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fw_req  in  1  FireWire requests burst ownership; level, held for entire burst
- fw_strobe  in  1  FireWire read this cycle; valid only while fw_gnt=1
- fw_raddr  in  16  FireWire read address
- fw_gnt  out  1  FireWire owns the port
- fw_rvalid  out  1  hub_rdata valid for FireWire
- eth_req  in  1  Ethernet burst request
- eth_strobe  in  1  Ethernet read strobe
- eth_raddr  in  16  Ethernet read address
- eth_gnt  out  1  Ethernet owns the port
- eth_rvalid  out  1  hub_rdata valid for Ethernet
- reg_raddr  out  16  address to hub register block
- reg_rdata  in  32  data from hub register block
- hub_rdata  out  32  reg_rdata registered-through (shared; qualified by *_rvalid)
- bc_query  in  1  broadcast query write (hub_reg_wen); clears sticky status
- to_pulse  out  1  one-cycle pulse on timeout revoke
- arb_status  out  16  {fw_to, eth_to, owner[1:0], 4'd0, last_len[7:0]}

Behaviour:
- Reset: all outputs 0; state IDLE; rr_last=ETH, so FireWire wins the first tie.
- States:
  - IDLE: no grant. reg_raddr=16'h0000 (outside hub space, so translation is undisturbed).
  - GNT_FW / GNT_ETH: reg_raddr = owner's raddr (combinational mux on state).
  - DRAIN: waits RD_LAT cycles with no grant, then returns to IDLE.
- IDLE arbitration:
  - Single requester: grant it next cycle (fw_gnt/eth_gnt registered, so 1 cycle from req to gnt).
  - Both requesting: grant the one not equal to rr_last; update rr_last on grant.
- GNT_x:
  - Each cycle with x_strobe=1: x_rvalid asserts exactly RD_LAT cycles later; burst counter increments, saturating at 255.
  - Strobes by the non-owner are ignored; no rvalid is generated for them.
- Release: x_req low in GNT_x -> gnt low next cycle, enter DRAIN. Strobes issued in the cycle req falls are still honoured.
- DRAIN: in-flight rvalids still complete. last_len <= burst count; burst count cleared.
- Timeout:
  - In GNT_x, the counter increments each cycle without a strobe and clears on a strobe.
  - At count==TIMEOUT_CYC-1: revoke gnt, pulse to_pulse, set x_to sticky, enter DRAIN.
  - The requester must drop req before re-arbitration. A timed-out requester with req still high is not regranted until req has been seen low for 1 cycle (per-source rearm flag).
- owner field: 01=FW, 10=ETH, 00=none; reflects current gnt.
- bc_query: clears fw_to/eth_to. If it coincides with a timeout set, the set wins. Ownership is not affected.
- The hub_rdata pipeline is RD_LAT-deep. rvalid pipelines are independent shift registers tagged per source.
- Reset mid-burst: immediate return to IDLE; all gnt/rvalid low asynchronously.

Decomposition:
- Shared constants package: ADDR_HUB, state encodings (IDLE, GNT_FW, GNT_ETH, DRAIN), owner codes, default TIMEOUT_CYC.
- One sub-module: hub_rd_valid_pipe. It is an RD_LAT-deep 2-bit shift register (fw/eth tags), instantiated once.

Test Plan:
- FW only: fw_req, 29 strobes at 0x1000..0x101C -> fw_gnt 1 cycle after req; fw_rvalid 29 times, each 1 cycle after its strobe; last_len=29.
- Simultaneous fw_req/eth_req after reset -> FW granted first. After FW release, DRAIN 1 cycle, then eth_gnt. reg_raddr never shows an eth address during the FW burst.
- eth_req rises mid-FW burst -> no eth_gnt until FW releases. FW burst addresses stay contiguous; a second tie goes to ETH (round-robin).
- FW granted, no strobe for 1024 cycles -> fw_gnt drops, to_pulse=1 for one cycle, arb_status[15]=1. fw_req held high gets no regrant until toggled low.
- bc_query after timeout -> arb_status[15:14]=0. Simultaneous bc_query and eth timeout -> eth_to=1.
- reset asserted mid-ETH burst -> eth_gnt, eth_rvalid, reg_raddr all 0 asynchronously. After release, a fresh eth_req is granted normally.
